// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, state encoding and helpers for the interrupt
// path (priority encoder, pending latch, dispatcher).
package irq_pkg;

  localparam int unsigned N_IRQ    = 4;
  localparam int unsigned IRQ_ID_W = 2;

  // Default vector table placement: ID 0 at 0x100, 16-byte spacing.
  localparam logic [31:0] DEF_VEC_BASE       = 32'h0000_0100;
  localparam int unsigned DEF_VEC_STRIDE_LG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Handler address for an interrupt ID; the add wraps at 32 bits.
  function automatic logic [31:0] vec_addr(
    input logic [31:0]         base,
    input int unsigned         stride_lg2,
    input logic [IRQ_ID_W-1:0] id
  );
    logic [31:0] offset;
    offset = 32'(id) << stride_lg2;
    return base + offset;
  endfunction

  // One-hot mask selecting the given ID in the pending latch.
  function automatic logic [N_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [N_IRQ-1:0] one;
    one = N_IRQ'(1);
    return one << id;
  endfunction

endpackage

// File: rtl/irq_ack_timer.sv
// irq_ack_timer: counts cycles a request waits for acknowledge.
// Only instantiated when IRQ_DISPATCH_TIMEOUT_EN is defined.
// o_last is registered and marks the final cycle the request may stay
// pending; if it is still unacknowledged at that edge the count reaches
// ACK_TIMEOUT and the dispatcher abandons it.
module irq_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_last
);

  localparam logic [7:0] LAST_COUNT = 8'(ACK_TIMEOUT - 32'd1);
  localparam logic       LAST_AT_ZERO = (LAST_COUNT == 8'd0);

  logic [7:0] r_count;
  logic       r_last;
  logic [7:0] w_count_inc;

  assign w_count_inc = r_count + 8'd1;

  // Wait counter: held at zero outside REQ, advances on each unacked REQ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
      r_last  <= LAST_AT_ZERO;
    end else if (i_clear) begin
      r_count <= 8'd0;
      r_last  <= LAST_AT_ZERO;
    end else if (i_run) begin
      r_count <= w_count_inc;
      r_last  <= (w_count_inc == LAST_COUNT);
    end else begin
      r_count <= r_count;
      r_last  <= r_last;
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/irq_dispatcher.sv
// irq_dispatcher: turns the encoder's winning ID into a CPU request with a
// vector address and runs the request / ack / end-of-interrupt handshake.
// On ack it pulses a one-hot clear to the pending latch.
// Optional feature: define IRQ_DISPATCH_TIMEOUT_EN to abandon requests that
// are not acknowledged within ACK_TIMEOUT cycles.
module irq_dispatcher
  import irq_pkg::*;
#(
  parameter logic [31:0] VEC_BASE       = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE_LG2 = DEF_VEC_STRIDE_LG2,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_in,
  input  logic [IRQ_ID_W-1:0] irq_id,
  input  logic                cpu_ack,
  input  logic                cpu_eoi,
  output logic                cpu_irq,
  output logic [31:0]         cpu_vector,
  output logic [N_IRQ-1:0]    clr_pending,
  output logic [IRQ_ID_W-1:0] active_id,
  output logic                busy,
  output logic                timeout
);

  // Reject timeout settings the 8-bit timer cannot represent.
  if ((ACK_TIMEOUT < 32'd1) || (ACK_TIMEOUT > 32'd255)) begin : g_bad_ack_timeout
    $error("irq_dispatcher: ACK_TIMEOUT must be within 1..255");
  end

  irq_state_e          r_state;
  logic                r_cpu_irq;
  logic [31:0]         r_cpu_vector;
  logic [N_IRQ-1:0]    r_clr_pending;
  logic [IRQ_ID_W-1:0] r_active_id;
  logic                r_busy;
  logic                r_timeout;

  logic w_expire;
  logic w_preempt;

  // A strictly higher-priority source (lower ID) may replace the pending one.
  assign w_preempt = irq_in && (irq_id < r_active_id);

`ifdef IRQ_DISPATCH_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_run;
  logic w_timer_last;

  assign w_timer_clear = (r_state != ST_REQ);
  assign w_timer_run   = (r_state == ST_REQ) && !cpu_ack;

  irq_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_timer_clear),
    .i_run   (w_timer_run),
    .o_last  (w_timer_last)
  );

  // An ack arriving on the expiry cycle wins because w_timer_run excludes it.
  assign w_expire = w_timer_run && w_timer_last;
`else
  assign w_expire = 1'b0;
`endif

  // Dispatch FSM; every output is produced directly from this register set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cpu_irq     <= 1'b0;
      r_cpu_vector  <= 32'd0;
      r_clr_pending <= '0;
      r_active_id   <= '0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      // Pulses default low and are raised only on their triggering edge.
      r_clr_pending <= '0;
      r_timeout     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (irq_in) begin
            r_state      <= ST_REQ;
            r_active_id  <= irq_id;
            r_cpu_irq    <= 1'b1;
            r_cpu_vector <= vec_addr(VEC_BASE, VEC_STRIDE_LG2, irq_id);
            r_busy       <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_cpu_irq    <= 1'b0;
            r_cpu_vector <= 32'd0;
            r_busy       <= 1'b0;
          end
        end
        ST_REQ: begin
          if (cpu_ack) begin
            // Ack applies to the ID presented this cycle, even if a
            // higher-priority source shows up at the same time.
            r_state       <= ST_SERVICE;
            r_cpu_irq     <= 1'b0;
            r_cpu_vector  <= 32'd0;
            r_clr_pending <= id_onehot(r_active_id);
            r_busy        <= 1'b1;
          end else if (w_expire) begin
            // Abandon without clearing the pending bit so it re-arbitrates.
            r_state      <= ST_IDLE;
            r_cpu_irq    <= 1'b0;
            r_cpu_vector <= 32'd0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b1;
          end else if (w_preempt) begin
            r_state      <= ST_REQ;
            r_active_id  <= irq_id;
            r_cpu_irq    <= 1'b1;
            r_cpu_vector <= vec_addr(VEC_BASE, VEC_STRIDE_LG2, irq_id);
            r_busy       <= 1'b1;
          end else begin
            r_state      <= ST_REQ;
            r_cpu_irq    <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_SERVICE: begin
          // No nesting: new requests wait until the handler signals eoi.
          if (cpu_eoi) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_SERVICE;
            r_busy  <= 1'b1;
          end
          r_cpu_irq    <= 1'b0;
          r_cpu_vector <= 32'd0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cpu_irq    <= 1'b0;
          r_cpu_vector <= 32'd0;
          r_active_id  <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq     = r_cpu_irq;
  assign cpu_vector  = r_cpu_vector;
  assign clr_pending = r_clr_pending;
  assign active_id   = r_active_id;
  assign busy        = r_busy;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_irq_dispatcher.sv
// tb_irq_dispatcher: directed stimulus with a scoreboard of expected output
// events (request/vector, clear pulse, timeout pulse) checked by a monitor.
module tb_irq_dispatcher;

  localparam logic [1:0] K_REQ = 2'd0;
  localparam logic [1:0] K_CLR = 2'd1;
  localparam logic [1:0] K_TMO = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        irq_in;
  logic [1:0]  irq_id;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        cpu_irq;
  logic [31:0] cpu_vector;
  logic [3:0]  clr_pending;
  logic [1:0]  active_id;
  logic        busy;
  logic        timeout;

  ev_t sb[$];
  int  total;
  int  bad;
  logic        last_irq;
  logic [31:0] last_vec;

  irq_dispatcher #(
    .VEC_BASE       (32'h0000_0100),
    .VEC_STRIDE_LG2 (4),
    .ACK_TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .irq_id      (irq_id),
    .cpu_ack     (cpu_ack),
    .cpu_eoi     (cpu_eoi),
    .cpu_irq     (cpu_irq),
    .cpu_vector  (cpu_vector),
    .clr_pending (clr_pending),
    .active_id   (active_id),
    .busy        (busy),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic see(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %h expected none", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.val !== v) begin
        bad++;
        $display("FAIL event: got kind %0d val %h expected kind %0d val %h",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  // Advance n rising edges, then step off the edge before driving.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  initial begin
    last_irq = 1'b0;
    last_vec = 32'd0;
    forever begin
      @(negedge clk);
      if (cpu_irq === 1'b1 && (last_irq !== 1'b1 || cpu_vector !== last_vec))
        see(K_REQ, cpu_vector);
      if (clr_pending !== 4'd0 && !$isunknown(clr_pending))
        see(K_CLR, {26'd0, active_id, clr_pending});
      if (timeout === 1'b1)
        see(K_TMO, 32'd0);
      last_irq = cpu_irq;
      last_vec = cpu_vector;
    end
  end

  // Watchdog against any unbounded stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    irq_in  = 1'b0;
    irq_id  = 2'd0;
    cpu_ack = 1'b0;
    cpu_eoi = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("rst_irq", {31'd0, cpu_irq}, 32'd0);
    chk("rst_vec", cpu_vector, 32'd0);
    chk("rst_clr", {28'd0, clr_pending}, 32'd0);
    chk("rst_aid", {30'd0, active_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tmo", {31'd0, timeout}, 32'd0);

    // Basic handshake with ID 2.
    irq_in = 1'b1; irq_id = 2'd2;
    push(K_REQ, 32'h120);
    cyc(1);
    irq_in = 1'b0;
    chk("t1_busy_req", {31'd0, busy}, 32'd1);
    cyc(2);
    cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd2, 4'b0100});
    cyc(1);
    cpu_ack = 1'b0;
    chk("t1_irq_svc", {31'd0, cpu_irq}, 32'd0);
    chk("t1_busy_svc", {31'd0, busy}, 32'd1);
    cyc(2);
    cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Re-arbitration: ID 3 pending, ID 0 preempts.
    irq_in = 1'b1; irq_id = 2'd3;
    push(K_REQ, 32'h130);
    cyc(1);
    irq_id = 2'd0;
    push(K_REQ, 32'h100);
    cyc(1);
    irq_in = 1'b0;
    chk("t2_irq_held", {31'd0, cpu_irq}, 32'd1);
    chk("t2_vec", cpu_vector, 32'h100);
    cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd0, 4'b0001});
    cyc(1);
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;

    // Ack and a higher-priority ID in the same cycle: ack wins.
    irq_in = 1'b1; irq_id = 2'd2;
    push(K_REQ, 32'h120);
    cyc(1);
    irq_id = 2'd1; cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd2, 4'b0100});
    cyc(1);
    irq_in = 1'b0; cpu_ack = 1'b0;
    chk("t3_aid", {30'd0, active_id}, 32'd2);
    chk("t3_irq", {31'd0, cpu_irq}, 32'd0);
    cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;

    // Stray ack in IDLE, stray eoi in REQ, irq during SERVICE.
    cpu_ack = 1'b1;
    cyc(2);
    cpu_ack = 1'b0;
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_irq", {31'd0, cpu_irq}, 32'd0);
    irq_in = 1'b1; irq_id = 2'd1;
    push(K_REQ, 32'h110);
    cyc(1);
    irq_in = 1'b0; cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;
    chk("t4_req_irq", {31'd0, cpu_irq}, 32'd1);
    chk("t4_req_busy", {31'd0, busy}, 32'd1);
    cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd1, 4'b0010});
    cyc(1);
    cpu_ack = 1'b0;
    irq_in = 1'b1; irq_id = 2'd0;
    cyc(3);
    chk("t4_svc_irq", {31'd0, cpu_irq}, 32'd0);
    chk("t4_svc_aid", {30'd0, active_id}, 32'd1);
    cpu_eoi = 1'b1;
    push(K_REQ, 32'h100);
    cyc(1);
    cpu_eoi = 1'b0;
    chk("t4_turn_idle", {31'd0, cpu_irq}, 32'd0);
    cyc(1);
    irq_in = 1'b0;
    chk("t4_turn_req", {31'd0, cpu_irq}, 32'd1);
    chk("t4_turn_vec", cpu_vector, 32'h100);
    cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd0, 4'b0001});
    cyc(1);
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;

    // Reset while in SERVICE.
    irq_in = 1'b1; irq_id = 2'd3;
    push(K_REQ, 32'h130);
    cyc(1);
    irq_in = 1'b0; cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd3, 4'b1000});
    cyc(1);
    cpu_ack = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_aid", {30'd0, active_id}, 32'd0);
    chk("t5_clr", {28'd0, clr_pending}, 32'd0);
    chk("t5_irq", {31'd0, cpu_irq}, 32'd0);
    cyc(2);
    chk("t5_still_idle", {31'd0, busy}, 32'd0);

    // Unacknowledged request.
    irq_in = 1'b1; irq_id = 2'd1;
    push(K_REQ, 32'h110);
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    push(K_TMO, 32'd0);
`endif
    cyc(1);
    irq_in = 1'b0;
    n = 0;
    while (cpu_irq === 1'b1 && n < 120) begin
      n++;
      cyc(1);
    end
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    chk("t6_irq_cycles", n, 32'd16);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_clr", {28'd0, clr_pending}, 32'd0);
    cyc(2);
`else
    chk("t6_irq_cycles", n, 32'd120);
    chk("t6_timeout", {31'd0, timeout}, 32'd0);
    cpu_ack = 1'b1;
    push(K_CLR, {26'd0, 2'd1, 4'b0010});
    cyc(1);
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    cyc(1);
    cpu_eoi = 1'b0;
`endif

    cyc(3);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_dispatcher.md
# irq_dispatcher

Sequential interrupt dispatch stage directly downstream of `priority_encoder`. It consumes the encoder's winning ID (`y`) and active flag (`IRQ`), raises a registered request to the CPU with a vector address, and completes a request/acknowledge/end-of-interrupt handshake. On acknowledge it emits a one-hot clear pulse back to the pending-interrupt latch so the serviced source drops out of arbitration.

## Interface

- `VEC_BASE`, 32'h0000_0100, vector address of interrupt ID 0
- `VEC_STRIDE_LG2`, 4, log2 of byte spacing between vectors (16 B)
- `ACK_TIMEOUT`, 16, cycles in REQ before the request is abandoned (only with timeout enabled); legal range 1..255

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `irq_in`  in  1  encoder `IRQ`: an interrupt is pending
- `irq_id`  in  2  encoder `y`: winning ID, 0 = highest priority
- `cpu_ack`  in  1  CPU accepts the presented vector
- `cpu_eoi`  in  1  CPU finished the handler
- `cpu_irq`  out  1  interrupt request to the CPU
- `cpu_vector`  out  32  handler address; valid while `cpu_irq`=1
- `clr_pending`  out  4  one-hot, single-cycle clear to the pending latch
- `active_id`  out  2  ID currently requested or in service
- `busy`  out  1  high in REQ and SERVICE
- `timeout`  out  1  single-cycle pulse when a request is abandoned

## Operation

- States: IDLE, REQ, SERVICE. All outputs are registered.
- Reset: state=IDLE; `cpu_irq`=0, `cpu_vector`=0, `clr_pending`=0, `active_id`=0, `busy`=0, `timeout`=0, timer=0. This holds from any state, including mid-handshake.
- IDLE: when `irq_in`=1, latch `irq_id` into `active_id` and go to REQ. Otherwise stay in IDLE.
- REQ: `cpu_irq`=1 and `cpu_vector`=`VEC_BASE` + (`active_id` << `VEC_STRIDE_LG2`), using 32-bit wrap-around addition.
  - Re-arbitration: if `irq_in`=1, `irq_id` < `active_id`, and `cpu_ack`=0, replace `active_id` with `irq_id`. The vector updates on the next cycle.
  - On `cpu_ack`=1, go to SERVICE. The ack applies to the `active_id` registered in that cycle. If ack and a higher-priority ID arrive in the same cycle, the ack wins and no re-arbitration happens.
- SERVICE: `cpu_irq`=0 and `busy`=1. New `irq_in` is ignored; there is no nesting. On `cpu_eoi`=1, go to IDLE.
- `cpu_ack` outside REQ and `cpu_eoi` outside SERVICE are ignored and have no effect.
- `clr_pending` = 1 << `active_id` for exactly the first SERVICE cycle. It is 0 at all other times.

## Timing

- `irq_in` sampled high in IDLE at edge N → `cpu_irq`=1 and a valid vector from cycle N+1.
- `cpu_ack` sampled at edge M → `cpu_irq`=0 and `clr_pending` pulse in cycle M+1.
- `cpu_eoi` sampled at edge K → IDLE in cycle K+1. `irq_in` sampled at edge K+1 gives `cpu_irq` in cycle K+2.
- Minimum turnaround from eoi to the next request: 2 cycles.
- Re-arbitration: the vector changes one cycle after the higher-priority ID is sampled, and `cpu_irq` stays high throughout.

## Configuration

- `IRQ_DISPATCH_TIMEOUT_EN` defined:
  - An 8-bit timer clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches `ACK_TIMEOUT`, return to IDLE, drop `cpu_irq`, and pulse `timeout` for one cycle.
  - `clr_pending` is not pulsed, so the source re-arbitrates from IDLE.
  - An ack in the same cycle the timer expires wins.
- Undefined: no timer logic. `timeout` is tied to 0 and REQ waits indefinitely for `cpu_ack`.

## Structure

- Shared package `irq_pkg` holds:
  - `N_IRQ`=4 and `IRQ_ID_W`=2;
  - the state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2);
  - the default `VEC_BASE` and `VEC_STRIDE_LG2` constants.
- The encoder and the pending latch use the same package.
- One natural sub-module: `irq_ack_timer`, the timeout counter. It is instantiated only under `IRQ_DISPATCH_TIMEOUT_EN`.
- The FSM and vector computation stay in the top module.

## Test plan

- Reset mid-SERVICE (`rst`=1 for 1 cycle) → next cycle state IDLE, all outputs 0, no `clr_pending` pulse.
- `irq_id`=2 with `irq_in`=1 in IDLE → next cycle `cpu_irq`=1, `cpu_vector`=32'h120. Ack → `clr_pending`=4'b0100 for exactly one cycle. Eoi → IDLE.
- In REQ with `active_id`=3, `irq_id`=0 arrives without ack → `cpu_vector` changes 32'h130→32'h100. Ack → `clr_pending`=4'b0001.
- In REQ with `active_id`=2, ack and `irq_id`=1 arrive in the same cycle → SERVICE with `active_id`=2, `clr_pending`=4'b0100.
- `cpu_ack` in IDLE and `cpu_eoi` in REQ → no state change, no pulses. A new `irq_in` during SERVICE is ignored until eoi.
- Timeout enabled, `ACK_TIMEOUT`=16, no ack → `cpu_irq` high for 16 cycles, then `timeout` pulses once, state IDLE, `clr_pending` stays 0. Timeout disabled → `cpu_irq` held high for 100+ cycles.
